fifo_uart_drain: RTL

// - Return path of the camera FIFO link: pops bytes from the FIFO read port and hands them one at a

---
 rtl/fifo_uart_drain_pkg.sv | 22 ++
 rtl/fifo_uart_drain_if.sv | 23 ++
 rtl/fifo_uart_drain_busy_watchdog.sv | 46 ++++
 rtl/fifo_uart_drain.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fifo_uart_drain_pkg.sv
// Shared definitions for the FIFO-to-UART drain: state encoding and default byte width.
package fifo_uart_pkg;

    localparam int DEF_DATA_W = 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_POP      = 3'd1;
    localparam logic [2:0] S_WAIT_DAT = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_WAIT_HI  = 3'd4;
    localparam logic [2:0] S_WAIT_LO  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_POP      = S_POP,
        ST_WAIT_DAT = S_WAIT_DAT,
        ST_LOAD     = S_LOAD,
        ST_WAIT_HI  = S_WAIT_HI,
        ST_WAIT_LO  = S_WAIT_LO
    } state_e;

endpackage

// File: rtl/fifo_uart_drain_if.sv
// FIFO read port plus UART transmit handshake, bundled for the drain block.
interface fifo_uart_drain_if #(
    parameter int DW = fifo_uart_pkg::DEF_DATA_W
);
    logic          fifo_empy;
    logic [DW-1:0] fifo_datout;
    logic          fifo_rd;
    logic          tx_busy;
    logic [DW-1:0] tx_data;
    logic          tx_wr;

    // The drain side: pops the FIFO and writes the UART.
    modport master (
        input  fifo_empy, fifo_datout, tx_busy,
        output fifo_rd, tx_data, tx_wr
    );

    // The FIFO/UART side.
    modport slave (
        output fifo_empy, fifo_datout, tx_busy,
        input  fifo_rd, tx_data, tx_wr
    );
endinterface

// File: rtl/fifo_uart_drain_busy_watchdog.sv
// Watchdog armed by the UART write strobe: expires if tx_busy has not risen within BUSY_TO
// cycles, counting the write-strobe cycle as the first one. Needs BUSY_TO >= 2.
module busy_watchdog #(
    parameter int BUSY_TO = 16,
    parameter int W       = $clog2(BUSY_TO + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic busy_i,
    output logic expire_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         armed_q, armed_d;

    // Load on start, count down while busy stays low, stop on busy or on expiry.
    always_comb begin
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        expire_o = 1'b0;
        if (start_i) begin
            cnt_d   = W'(BUSY_TO - 1);
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (busy_i) begin
                armed_d = 1'b0;
            end else if (cnt_q <= W'(1)) begin
                expire_o = 1'b1;
                armed_d  = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter and arm flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: rtl/fifo_uart_drain.sv
// Drains the camera FIFO into the UART transmitter, one byte in flight at a time.
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = 16,
    parameter int BUSY_TO   = 16,
    parameter int MAX_BURST = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               err_clr,
    fifo_uart_drain_if.master  bus,
    output logic               active,
    output logic [CNT_W-1:0]   byte_cnt,
    output logic               err_timeout
);
    localparam int LAT_W = 2;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic               err_q, err_d;
    logic               expire;
    logic               burst_full;

    assign burst_full  = (MAX_BURST != 0) && (burst_q >= CNT_W'(MAX_BURST));
    assign active      = (state_q != ST_IDLE);
    assign byte_cnt    = cnt_q;
    assign err_timeout = err_q;
    assign bus.tx_data = tx_data_q;

    busy_watchdog #(
        .BUSY_TO (BUSY_TO)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .start_i  (state_q == ST_LOAD),
        .busy_i   (bus.tx_busy),
        .expire_o (expire)
    );

    // Next-state, strobes, byte capture and counters.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        tx_data_d   = tx_data_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        err_d       = err_q;
        bus.fifo_rd = 1'b0;
        bus.tx_wr   = 1'b0;

        // Clear first so a timeout in the same cycle takes priority.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en && !bus.fifo_empy && !bus.tx_busy && !burst_full) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                bus.fifo_rd = 1'b1;
                lat_d       = LAT_W'(RD_LAT - 1);
                state_d     = ST_WAIT_DAT;
            end
            ST_WAIT_DAT: begin
                if (lat_q == '0) begin
                    tx_data_d = bus.fifo_datout;
                    state_d   = ST_LOAD;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_LOAD: begin
                bus.tx_wr = 1'b1;
                state_d   = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (bus.tx_busy) begin
                    cnt_d   = cnt_q + 1'b1;
                    burst_d = burst_q + 1'b1;
                    state_d = ST_WAIT_LO;
                end else if (expire) begin
                    // UART never took the byte: drop it and flag the fault.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A burst session ends whenever enable drops.
        if (!en) begin
            burst_d = '0;
        end
    end

    // State, capture and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
        end
    end
endmodule
